// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 16-bit memory port between the CPU and a DMA engine. One access
//   is in flight at a time: IDLE -> ACCESS (MEM_LATENCY cycles of strobe) ->
//   DONE (one-cycle done pulse) -> IDLE. The CPU wins ties. A saturating
//   wait counter forces a DMA grant after MAX_WAIT CPU grants have gone by
//   while the DMA was waiting.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU request (level, held until grant)
//   cpu_grant, cpu_done             one-cycle pulses (accepted / complete)
//   cpu_rdata                       last CPU read data, held
//   dma_*                           same set for the DMA engine
//   mem_read, mem_write             memory strobes, held MEM_LATENCY cycles
//   mem_address, mem_wdata          latched access address / write data
//   mem_rdata                       memory read data, valid in last ACCESS cycle
//   busy                            high whenever state is not IDLE
//   owner                           0=CPU, 1=DMA for current/last access
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int MAX_WAIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_grant,
    output logic        cpu_done,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_grant,
    output logic        dma_done,
    output logic [15:0] dma_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q, we_d;
    logic        owner_q, owner_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;
    logic        cpu_grant_q, cpu_grant_d;
    logic        dma_grant_q, dma_grant_d;

    logic        accept;
    logic        pick_dma;

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        we_d        = we_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_grant_d = 1'b0;
        dma_grant_d = 1'b0;

        accept   = (state_q == S_IDLE) && (cpu_req || dma_req);
        // CPU wins unless the DMA has been passed over MAX_WAIT times.
        pick_dma = dma_req && (!cpu_req || (wait_cnt_q >= WAIT_MAX));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d     = pick_dma;
                    we_d        = pick_dma ? dma_we    : cpu_we;
                    addr_d      = pick_dma ? dma_addr  : cpu_addr;
                    wdata_d     = pick_dma ? dma_wdata : cpu_wdata;
                    lat_cnt_d   = LAT_INIT;
                    cpu_grant_d = !pick_dma;
                    dma_grant_d = pick_dma;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (lat_cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q) dma_rdata_d = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // An absent DMA request clears the starvation history.
        if (!dma_req) begin
            wait_cnt_d = 4'd0;
        end else if (accept) begin
            if (pick_dma)                   wait_cnt_d = 4'd0;
            else if (wait_cnt_q != 4'd15)   wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_cnt_q   <= 4'd0;
            wait_cnt_q  <= 4'd0;
            we_q        <= 1'b0;
            owner_q     <= 1'b0;
            addr_q      <= 16'd0;
            wdata_q     <= 16'd0;
            cpu_rdata_q <= 16'd0;
            dma_rdata_q <= 16'd0;
            cpu_grant_q <= 1'b0;
            dma_grant_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_grant_q <= cpu_grant_d;
            dma_grant_q <= dma_grant_d;
        end
    end

    // Strobes and dones decode straight from registered state, so a reset
    // that lands mid-access drops them on the very next cycle.
    assign mem_read    = (state_q == S_ACCESS) && !we_q;
    assign mem_write   = (state_q == S_ACCESS) &&  we_q;
    assign cpu_done    = (state_q == S_DONE)   && !owner_q;
    assign dma_done    = (state_q == S_DONE)   &&  owner_q;
    assign cpu_grant   = cpu_grant_q;
    assign dma_grant   = dma_grant_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dma_rdata   = dma_rdata_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = (state_q != S_IDLE);
    assign owner       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Main instance uses MEM_LATENCY=2,
// MAX_WAIT=4; a second instance with MEM_LATENCY=1 covers back-to-back reads.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic        cpu_grant, cpu_done, dma_grant, dma_done;
    logic [15:0] cpu_rdata, dma_rdata, mem_address, mem_wdata;
    logic        mem_read, mem_write, busy, owner;

    logic        cpu_req2;
    logic [15:0] cpu_addr2;
    logic        cpu_grant2, cpu_done2, dma_grant2, dma_done2;
    logic [15:0] cpu_rdata2, dma_rdata2, mem_address2, mem_wdata2, mem_rdata2;
    logic        mem_read2, mem_write2, busy2, owner2;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.MEM_LATENCY(2), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_grant(cpu_grant), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_grant(dma_grant), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Second port's memory returns address ^ 0xA500.
    assign mem_rdata2 = mem_address2 ^ 16'hA500;

    mem_port_arbiter #(.MEM_LATENCY(1), .MAX_WAIT(4)) dut2 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req2), .cpu_we(1'b0), .cpu_addr(cpu_addr2), .cpu_wdata(16'h0000),
        .cpu_grant(cpu_grant2), .cpu_done(cpu_done2), .cpu_rdata(cpu_rdata2),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0000), .dma_wdata(16'h0000),
        .dma_grant(dma_grant2), .dma_done(dma_done2), .dma_rdata(dma_rdata2),
        .mem_read(mem_read2), .mem_write(mem_write2), .mem_address(mem_address2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .busy(busy2), .owner(owner2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle timeout busy=%b want 0", name, busy);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        mem_rdata = 0; cpu_req2 = 0; cpu_addr2 = 0;
        step(); step();
        total++;
        if ({cpu_grant, cpu_done, dma_grant, dma_done, mem_read, mem_write, busy, owner} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl got %b want 00000000",
                     {cpu_grant, cpu_done, dma_grant, dma_done, mem_read, mem_write, busy, owner});
        end
        total++;
        if ({cpu_rdata, dma_rdata, mem_address, mem_wdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data got %h want 0", {cpu_rdata, dma_rdata, mem_address, mem_wdata});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040; mem_rdata = 16'hBEEF;
        step(); // cycle 1
        total++;
        if ({cpu_grant, dma_grant, mem_read, mem_write, busy, owner} !== 6'b101010 || mem_address !== 16'h0040) begin
            bad++;
            $display("FAIL cpu_read_c1 got g=%b dg=%b rd=%b wr=%b busy=%b own=%b addr=%h want 1 0 1 0 1 0 0040",
                     cpu_grant, dma_grant, mem_read, mem_write, busy, owner, mem_address);
        end
        cpu_req = 0;
        step(); // cycle 2
        total++;
        if ({cpu_grant, mem_read, cpu_done} !== 3'b010) begin
            bad++;
            $display("FAIL cpu_read_c2 got g=%b rd=%b done=%b want 0 1 0", cpu_grant, mem_read, cpu_done);
        end
        step(); // cycle 3
        total++;
        if ({cpu_done, dma_done, mem_read} !== 3'b100 || cpu_rdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL cpu_read_c3 got done=%b ddone=%b rd=%b rdata=%h want 1 0 0 beef",
                     cpu_done, dma_done, mem_read, cpu_rdata);
        end
        step(); // cycle 4
        total++;
        if (busy !== 1'b0 || cpu_done !== 1'b0) begin
            bad++;
            $display("FAIL cpu_read_c4 got busy=%b done=%b want 0 0", busy, cpu_done);
        end
    endtask

    task automatic test_both();
        int gap = 0;
        mem_rdata = 16'h2222;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0200;
        step();
        total++;
        if ({cpu_grant, dma_grant, owner} !== 3'b100) begin
            bad++;
            $display("FAIL both_first got cg=%b dg=%b own=%b want 1 0 0", cpu_grant, dma_grant, owner);
        end
        cpu_req = 0;
        while (!dma_grant && gap < 20) begin
            step();
            gap++;
        end
        total++;
        if (dma_grant !== 1'b1 || owner !== 1'b1 || gap !== 4 || mem_address !== 16'h0200) begin
            bad++;
            $display("FAIL both_dma got dg=%b own=%b gap=%0d addr=%h want 1 1 4 0200",
                     dma_grant, owner, gap, mem_address);
        end
        dma_req = 0;
        wait_idle("both");
        total++;
        if (cpu_rdata !== 16'h2222 || dma_rdata !== 16'h2222) begin
            bad++;
            $display("FAIL both_rdata got c=%h d=%h want 2222 2222", cpu_rdata, dma_rdata);
        end
    endtask

    task automatic test_starvation();
        logic exp_own [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic got_own [6];
        int   gcyc [6];
        int   n = 0;
        mem_rdata = 16'h3333;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0300;
        dma_req = 1; dma_we = 1; dma_addr = 16'h0400; dma_wdata = 16'h0044;
        for (int c = 0; c < 60 && n < 6; c++) begin
            step();
            if (cpu_grant || dma_grant) begin
                got_own[n] = dma_grant;
                gcyc[n] = c;
                n++;
                if (dma_grant) dma_req = 0;
            end
        end
        cpu_req = 0;
        total++;
        if (n !== 6) begin
            bad++;
            $display("FAIL starve_count got %0d grants want 6", n);
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (got_own[i] !== exp_own[i] || (i > 0 && gcyc[i] - gcyc[i-1] !== 4)) begin
                    bad++;
                    $display("FAIL starve_grant%0d got dma=%b gap=%0d want dma=%b gap=4",
                             i, got_own[i], (i > 0) ? gcyc[i] - gcyc[i-1] : 4, exp_own[i]);
                end
            end
        end
        wait_idle("starve");
        total++;
        if (cpu_rdata !== 16'h3333 || dma_rdata !== 16'h2222) begin
            bad++;
            $display("FAIL starve_rdata got c=%h d=%h want 3333 2222", cpu_rdata, dma_rdata);
        end
    endtask

    task automatic test_dma_write();
        mem_rdata = 16'hDEAD;
        dma_req = 1; dma_we = 1; dma_addr = 16'h1234; dma_wdata = 16'h00A5;
        step(); // cycle 1
        total++;
        if ({dma_grant, mem_write, mem_read, owner} !== 4'b1101 || mem_address !== 16'h1234 || mem_wdata !== 16'h00A5) begin
            bad++;
            $display("FAIL dmaw_c1 got dg=%b wr=%b rd=%b own=%b addr=%h wd=%h want 1 1 0 1 1234 00a5",
                     dma_grant, mem_write, mem_read, owner, mem_address, mem_wdata);
        end
        dma_req = 0;
        step(); // cycle 2
        total++;
        if ({mem_write, mem_read, dma_done} !== 3'b100) begin
            bad++;
            $display("FAIL dmaw_c2 got wr=%b rd=%b done=%b want 1 0 0", mem_write, mem_read, dma_done);
        end
        step(); // cycle 3
        total++;
        if ({mem_write, dma_done, cpu_done} !== 3'b010 || dma_rdata !== 16'h2222 || cpu_rdata !== 16'h3333) begin
            bad++;
            $display("FAIL dmaw_c3 got wr=%b dd=%b cd=%b d=%h c=%h want 0 1 0 2222 3333",
                     mem_write, dma_done, cpu_done, dma_rdata, cpu_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        mem_rdata = 16'h5555;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0080;
        step(); // cycle 1
        cpu_req = 0;
        step(); // cycle 2, second ACCESS cycle
        total++;
        if (mem_read !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_c2 got rd=%b want 1", mem_read);
        end
        reset = 1;
        step();
        reset = 0;
        total++;
        if ({busy, mem_read, mem_write, cpu_done, owner} !== 5'b0 || cpu_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_c3 got busy=%b rd=%b wr=%b done=%b own=%b rdata=%h want 0 0 0 0 0 0000",
                     busy, mem_read, mem_write, cpu_done, owner, cpu_rdata);
        end
        step();
        total++;
        if (cpu_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_c4 got done=%b busy=%b want 0 0", cpu_done, busy);
        end
    endtask

    task automatic test_back_to_back();
        cpu_req2 = 1; cpu_addr2 = 16'h0001;
        step(); // cycle 1
        total++;
        if (cpu_grant2 !== 1'b1 || mem_read2 !== 1'b1 || mem_address2 !== 16'h0001) begin
            bad++;
            $display("FAIL b2b_g1 got g=%b rd=%b addr=%h want 1 1 0001", cpu_grant2, mem_read2, mem_address2);
        end
        cpu_addr2 = 16'h0002;
        step(); // cycle 2: DONE
        total++;
        if (cpu_done2 !== 1'b1 || mem_read2 !== 1'b0 || cpu_rdata2 !== 16'hA501) begin
            bad++;
            $display("FAIL b2b_d1 got done=%b rd=%b rdata=%h want 1 0 a501", cpu_done2, mem_read2, cpu_rdata2);
        end
        cpu_req2 = 0;
        step(); // cycle 3: IDLE
        total++;
        if (busy2 !== 1'b0 || cpu_grant2 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got busy=%b g=%b want 0 0", busy2, cpu_grant2);
        end
        cpu_req2 = 1;
        step(); // cycle 4: second grant, 3 cycles after the first
        total++;
        if (cpu_grant2 !== 1'b1 || mem_read2 !== 1'b1 || mem_address2 !== 16'h0002) begin
            bad++;
            $display("FAIL b2b_g2 got g=%b rd=%b addr=%h want 1 1 0002", cpu_grant2, mem_read2, mem_address2);
        end
        cpu_req2 = 0;
        step(); // cycle 5
        total++;
        if (cpu_done2 !== 1'b1 || mem_read2 !== 1'b0 || cpu_rdata2 !== 16'hA502) begin
            bad++;
            $display("FAIL b2b_d2 got done=%b rd=%b rdata=%h want 1 0 a502", cpu_done2, mem_read2, cpu_rdata2);
        end
        step();
        total++;
        if ({busy2, dma_grant2, dma_done2, mem_write2, owner2} !== 5'b0 || {dma_rdata2, mem_wdata2} !== 32'h0) begin
            bad++;
            $display("FAIL b2b_quiet got %b %h want 0",
                     {busy2, dma_grant2, dma_done2, mem_write2, owner2}, {dma_rdata2, mem_wdata2});
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_both();
        test_starvation();
        test_dma_write();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
